// File: rtl/playfield_store_if.sv
// Bus between the game logic / colour mapper and the playfield store:
// lock and clear requests, the four block positions, the pixel and probe
// queries, and the status returned by the store.
interface playfield_store_if;
    logic       lock_req;
    logic       clear_board;
    logic [9:0] BallX,  BallY;
    logic [9:0] BallX2, BallY2;
    logic [9:0] BallX3, BallY3;
    logic [9:0] BallX4, BallY4;
    logic [9:0] DrawX,  DrawY;
    logic [9:0] probe_x, probe_y;
    logic       game_piece;
    logic       probe_hit;
    logic       busy;
    logic       done;
    logic [7:0] lines_cleared;
    logic       top_out;

    modport master (
        output lock_req, clear_board,
        output BallX, BallY, BallX2, BallY2, BallX3, BallY3, BallX4, BallY4,
        output DrawX, DrawY, probe_x, probe_y,
        input  game_piece, probe_hit, busy, done, lines_cleared, top_out
    );

    modport slave (
        input  lock_req, clear_board,
        input  BallX, BallY, BallX2, BallY2, BallX3, BallY3, BallX4, BallY4,
        input  DrawX, DrawY, probe_x, probe_y,
        output game_piece, probe_hit, busy, done, lines_cleared, top_out
    );
endinterface

// File: rtl/playfield_store.sv
// Locked-block playfield: a COLS x ROWS array of cells. Stamps the falling
// piece on lock_req, then walks the rows bottom-up removing full rows with a
// one-row gravity shift per cleared row. Also answers per-pixel occupancy
// for the colour mapper and a cell probe for move legality.
module playfield_store #(
    parameter int FIELD_X0 = 200,
    parameter int CELL     = 20,
    parameter int COLS     = 10,
    parameter int ROWS     = 20
) (
    input  logic Clk,
    input  logic Reset,
    playfield_store_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t            state, state_next;
    logic [4:0]        scan_row;
    logic [COLS-1:0]   cells [ROWS];
    logic [7:0]        lines_cleared;
    logic              top_out;

    logic [9:0]        bx [4];
    logic [9:0]        by [4];
    logic              blk_in  [4];
    logic [4:0]        blk_row [4];
    logic [3:0]        blk_col [4];
    logic              row_full;

    // Pixel lies inside the playfield rectangle.
    function automatic logic in_field(input logic [9:0] x, input logic [9:0] y);
        return (x >= 10'(FIELD_X0)) && (x < 10'(FIELD_X0 + COLS*CELL)) &&
               (y < 10'(ROWS*CELL));
    endfunction

    // Column index by comparing against each cell's left edge; only
    // meaningful when the pixel is in the field.
    function automatic logic [3:0] col_of(input logic [9:0] x);
        logic [3:0] c;
        c = '0;
        for (int i = 1; i < COLS; i++)
            if (x >= 10'(FIELD_X0 + i*CELL)) c = 4'(i);
        return c;
    endfunction

    // Row index by comparing against each cell's top edge.
    function automatic logic [4:0] row_of(input logic [9:0] y);
        logic [4:0] r;
        r = '0;
        for (int i = 1; i < ROWS; i++)
            if (y >= 10'(i*CELL)) r = 5'(i);
        return r;
    endfunction

    // Map the four block positions to cells once, for the stamp logic.
    always_comb begin
        bx[0] = bus.BallX;  by[0] = bus.BallY;
        bx[1] = bus.BallX2; by[1] = bus.BallY2;
        bx[2] = bus.BallX3; by[2] = bus.BallY3;
        bx[3] = bus.BallX4; by[3] = bus.BallY4;
        for (int b = 0; b < 4; b++) begin
            blk_in[b]  = in_field(bx[b], by[b]);
            blk_row[b] = row_of(by[b]);
            blk_col[b] = col_of(bx[b]);
        end
    end

    assign row_full = &cells[scan_row];

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: a lock starts the bottom-up scan; a full row detours
    // through SHIFT and comes back to recheck the same row.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.clear_board && bus.lock_req) state_next = SCAN;
            SCAN:    if (row_full)            state_next = SHIFT;
                     else if (scan_row == '0) state_next = DONE;
            SHIFT:   state_next = SCAN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Cell array, scan pointer and status: wipe, stamp, and gravity shift.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < ROWS; r++) cells[r] <= '0;
            scan_row      <= '0;
            lines_cleared <= '0;
            top_out       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear_board) begin
                        for (int r = 0; r < ROWS; r++) cells[r] <= '0;
                        lines_cleared <= '0;
                        top_out       <= 1'b0;
                    end else if (bus.lock_req) begin
                        for (int b = 0; b < 4; b++) begin
                            if (blk_in[b]) begin
                                cells[blk_row[b]][blk_col[b]] <= 1'b1;
                                if (blk_row[b] == '0) top_out <= 1'b1;
                            end
                        end
                        scan_row <= 5'(ROWS-1);
                    end
                end
                SCAN: begin
                    if (!row_full && scan_row != '0) scan_row <= scan_row - 5'd1;
                end
                SHIFT: begin
                    for (int r = ROWS-1; r >= 1; r--)
                        if (5'(r) <= scan_row) cells[r] <= cells[r-1];
                    cells[0] <= '0;
                    if (lines_cleared != 8'hFF) lines_cleared <= lines_cleared + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.game_piece    = in_field(bus.DrawX, bus.DrawY) &
                               cells[row_of(bus.DrawY)][col_of(bus.DrawX)];
    assign bus.probe_hit     = !in_field(bus.probe_x, bus.probe_y) |
                               cells[row_of(bus.probe_y)][col_of(bus.probe_x)];
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.lines_cleared = lines_cleared;
    assign bus.top_out       = top_out;

endmodule
